div_operand_sequencer: RTL

Operand issue and result capture stage wrapped around the fixed-point divider. Buffers incoming 10-bit dividend/divisor pairs in a small FIFO, launches one division at a time with a single-cycle `start` pulse, and captures the quotient and status flags into a holding register with a valid/ready output handshake. Divide-by-zero pairs bypass the divider. A watchdog aborts a division that never completes.

---
 rtl/div_operand_sequencer_if.sv | 52 +++++
 rtl/div_operand_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : div_operand_sequencer_if
// Purpose  : Operand input, divider side-band and result output signal bundle.
// Revision : 1.0
// ============================================================================
interface div_operand_sequencer_if #(
    parameter int W     = 10,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH) + 1;

    // Operand input stream
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;

    // Divider side
    logic [W-1:0]  div_A;
    logic [W-1:0]  div_B;
    logic          div_start;
    logic          div_valid;
    logic [W-1:0]  div_q;
    logic          div_ovf;

    // Result output stream
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_q;
    logic          res_dvz;
    logic          res_ovf;
    logic          res_err;
    logic [1:0]    res_tag;

    logic [OW-1:0] occupancy;

    // Environment side: operand producer, divider model and result consumer
    modport master (
        output in_valid, in_a, in_b, div_valid, div_q, div_ovf, res_ready,
        input  in_ready, div_A, div_B, div_start, res_valid, res_q, res_dvz,
               res_ovf, res_err, res_tag, occupancy
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, div_valid, div_q, div_ovf, res_ready,
        output in_ready, div_A, div_B, div_start, res_valid, res_q, res_dvz,
               res_ovf, res_err, res_tag, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/div_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_operand_sequencer
// Purpose  : Operand FIFO, divider launch/watchdog and result holding register.
// Revision : 1.0
// ============================================================================
module div_operand_sequencer #(
    parameter int W       = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  wire logic               clk_i,
    input  wire logic               rstn_i,
    input  wire logic               sclr_i,
    div_operand_sequencer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 2 + 2 * W;

    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      tag_q, tag_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      cur_tag_q, cur_tag_d;
    logic            start_q, start_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [W-1:0]    res_q_q, res_q_d;
    logic            res_dvz_q, res_dvz_d;
    logic            res_ovf_q, res_ovf_d;
    logic            res_err_q, res_err_d;
    logic [1:0]      res_tag_q, res_tag_d;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_head;
    logic [1:0]      w_head_tag;
    logic [W-1:0]    w_head_a;
    logic [W-1:0]    w_head_b;
    logic            w_timeout;

    assign w_full     = (count_q == C_DEPTH);
    assign w_empty    = (count_q == '0);
    assign w_push     = bus.in_valid && !w_full;
    assign w_pop      = (state_q == S_IDLE) && !w_empty;
    assign w_head     = mem_q[rd_ptr_q];
    assign w_head_tag = w_head[EW-1 -: 2];
    assign w_head_a   = w_head[2*W-1 -: W];
    assign w_head_b   = w_head[W-1:0];
    assign w_timeout  = (wait_cnt_q == C_TMO_LAST);

    // Storage needs no reset: entries are only read while count_q says they are valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {tag_q, bus.in_a, bus.in_b};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tag_d    = tag_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            tag_d    = tag_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cur_tag_d   = cur_tag_q;
        start_d     = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        res_valid_d = res_valid_q;
        res_q_d     = res_q_q;
        res_dvz_d   = res_dvz_q;
        res_ovf_d   = res_ovf_q;
        res_err_d   = res_err_q;
        res_tag_d   = res_tag_q;

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    a_d       = w_head_a;
                    b_d       = w_head_b;
                    cur_tag_d = w_head_tag;
                    // A zero divisor never reaches the divider
                    if (w_head_b == '0) begin
                        state_d     = S_HOLD;
                        res_valid_d = 1'b1;
                        res_q_d     = '1;
                        res_dvz_d   = 1'b1;
                        res_ovf_d   = 1'b0;
                        res_err_d   = 1'b0;
                        res_tag_d   = w_head_tag;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle takes priority over the abort
                if (bus.div_valid) begin
                    state_d     = S_HOLD;
                    res_valid_d = 1'b1;
                    res_q_d     = bus.div_q;
                    res_dvz_d   = 1'b0;
                    res_ovf_d   = bus.div_ovf;
                    res_err_d   = 1'b0;
                    res_tag_d   = cur_tag_q;
                end else if (w_timeout) begin
                    state_d     = S_HOLD;
                    res_valid_d = 1'b1;
                    res_q_d     = '0;
                    res_dvz_d   = 1'b0;
                    res_ovf_d   = 1'b0;
                    res_err_d   = 1'b1;
                    res_tag_d   = cur_tag_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cur_tag_q   <= '0;
            start_q     <= 1'b0;
            wait_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_q_q     <= '0;
            res_dvz_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
            res_tag_q   <= '0;
        end else if (sclr_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cur_tag_q   <= '0;
            start_q     <= 1'b0;
            wait_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_q_q     <= '0;
            res_dvz_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_q       <= tag_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cur_tag_q   <= cur_tag_d;
            start_q     <= start_d;
            wait_cnt_q  <= wait_cnt_d;
            res_valid_q <= res_valid_d;
            res_q_q     <= res_q_d;
            res_dvz_q   <= res_dvz_d;
            res_ovf_q   <= res_ovf_d;
            res_err_q   <= res_err_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.occupancy = count_q;
    assign bus.div_A     = a_q;
    assign bus.div_B     = b_q;
    assign bus.div_start = start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_q     = res_q_q;
    assign bus.res_dvz   = res_dvz_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_err   = res_err_q;
    assign bus.res_tag   = res_tag_q;

endmodule
`default_nettype wire
